jt49_mix_amp: RTL and testbench



---
 rtl/jt49_pkg.sv | 47 ++++
 rtl/jt49_log2lin.sv | 16 +
 rtl/jt49_mix_amp.sv | 108 ++++++++++
 tb/tb_jt49_mix_amp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt49_pkg : shared widths, sequencer phases and log-to-linear table |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jt49_pkg;

  localparam int LVL_W = 5;
  localparam int LIN_W = 8;
  localparam int SND_W = 10;

  localparam logic [1:0] PH_SNAP = 2'd0;
  localparam logic [1:0] PH_A    = 2'd1;
  localparam logic [1:0] PH_B    = 2'd2;
  localparam logic [1:0] PH_C    = 2'd3;

  // 1.5 dB per step below full scale, entry 0 is true silence
  localparam logic [LIN_W-1:0] LIN_TABLE [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };

  function automatic logic [LVL_W-1:0] gated_level(
    input logic             tone,
    input logic             noise,
    input logic             tone_dis,
    input logic             noise_dis,
    input logic [4:0]       amp,
    input logic [LVL_W-1:0] env,
    input logic             fixed_mute
  );
    logic             g;
    logic [LVL_W-1:0] l5;
    g = (tone | tone_dis) & (noise | noise_dis);
    if (amp[4])
      l5 = env;
    else if (fixed_mute && (amp[3:0] == 4'd0))
      l5 = '0;
    else
      l5 = {amp[3:0], 1'b1};
    return g ? l5 : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt49_log2lin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt49_log2lin : 5-bit log level to 8-bit linear amplitude lookup    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jt49_log2lin
  import jt49_pkg::*;
(
  input  logic [LVL_W-1:0] lvl,
  output logic [LIN_W-1:0] lin
);

  assign lin = LIN_TABLE[lvl];

endmodule
`default_nettype wire

// File: rtl/jt49_mix_amp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt49_mix_amp : mixer gating, amplitude select, shared log2lin, sum |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jt49_mix_amp
  import jt49_pkg::*;
#(
  parameter bit FIXED_MUTE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             tone_a,
  input  logic             tone_b,
  input  logic             tone_c,
  input  logic             noise,
  input  logic [5:0]       mixer,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [LVL_W-1:0] env,
  output logic [LVL_W-1:0] lvl_a,
  output logic [LVL_W-1:0] lvl_b,
  output logic [LVL_W-1:0] lvl_c,
  output logic [LIN_W-1:0] out_a,
  output logic [LIN_W-1:0] out_b,
  output logic [LIN_W-1:0] out_c,
  output logic [SND_W-1:0] sound,
  output logic             sample
);

  logic [1:0]       r_phase;
  logic             r_primed;
  logic [LIN_W-1:0] r_la;
  logic [LIN_W-1:0] r_lb;
  logic [LIN_W-1:0] r_lc;

  logic [LVL_W-1:0] w_gate_a;
  logic [LVL_W-1:0] w_gate_b;
  logic [LVL_W-1:0] w_gate_c;
  logic [LVL_W-1:0] w_lin_idx;
  logic [LIN_W-1:0] w_lin;
  logic [SND_W-1:0] w_sum;

  assign w_gate_a = gated_level(tone_a, noise, mixer[0], mixer[3], amp_a, env, FIXED_MUTE);
  assign w_gate_b = gated_level(tone_b, noise, mixer[1], mixer[4], amp_b, env, FIXED_MUTE);
  assign w_gate_c = gated_level(tone_c, noise, mixer[2], mixer[5], amp_c, env, FIXED_MUTE);

  // The single table walks the snapshot levels A, B, C on phases 1..3
  always_comb begin
    w_lin_idx = lvl_a;
    case (r_phase)
      PH_B:    w_lin_idx = lvl_b;
      PH_C:    w_lin_idx = lvl_c;
      default: w_lin_idx = lvl_a;
    endcase
  end

  jt49_log2lin u_log2lin (
    .lvl (w_lin_idx),
    .lin (w_lin)
  );

  assign w_sum = {2'b00, r_la} + {2'b00, r_lb} + {2'b00, r_lc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_SNAP;
      r_primed <= 1'b0;
      r_la     <= '0;
      r_lb     <= '0;
      r_lc     <= '0;
      lvl_a    <= '0;
      lvl_b    <= '0;
      lvl_c    <= '0;
      out_a    <= '0;
      out_b    <= '0;
      out_c    <= '0;
      sound    <= '0;
      sample   <= 1'b0;
    end else if (!cen) begin
      sample <= 1'b0;
    end else begin
      r_phase <= r_phase + 2'd1;
      sample  <= 1'b0;
      case (r_phase)
        PH_SNAP: begin
          lvl_a    <= w_gate_a;
          lvl_b    <= w_gate_b;
          lvl_c    <= w_gate_c;
          out_a    <= r_la;
          out_b    <= r_lb;
          out_c    <= r_lc;
          sound    <= w_sum;
          // The first snapshot after reset only publishes cleared accumulators
          sample   <= r_primed;
          r_primed <= 1'b1;
        end
        PH_A:    r_la <= w_lin;
        PH_B:    r_lb <= w_lin;
        default: r_lc <= w_lin;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt49_mix_amp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jt49_mix_amp : vector table plus scoreboard for jt49_mix_amp    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jt49_mix_amp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen = 1'b0;
  logic       tone_a = 1'b0, tone_b = 1'b0, tone_c = 1'b0, noise = 1'b0;
  logic [5:0] mixer = 6'h3F;
  logic [4:0] amp_a = 5'h0, amp_b = 5'h0, amp_c = 5'h0, env = 5'h0;

  logic [4:0] lvl_a, lvl_b, lvl_c;
  logic [7:0] out_a, out_b, out_c;
  logic [9:0] sound;
  logic       sample;

  logic [4:0] nm_lvl_a, nm_lvl_b, nm_lvl_c;
  logic [7:0] nm_out_a, nm_out_b, nm_out_c;
  logic [9:0] nm_sound;
  logic       nm_sample;

  always #5 clk = ~clk;

  jt49_mix_amp #(.FIXED_MUTE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .tone_a(tone_a), .tone_b(tone_b), .tone_c(tone_c), .noise(noise),
    .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .env(env),
    .lvl_a(lvl_a), .lvl_b(lvl_b), .lvl_c(lvl_c),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .sound(sound), .sample(sample)
  );

  jt49_mix_amp #(.FIXED_MUTE(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .tone_a(tone_a), .tone_b(tone_b), .tone_c(tone_c), .noise(noise),
    .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .env(env),
    .lvl_a(nm_lvl_a), .lvl_b(nm_lvl_b), .lvl_c(nm_lvl_c),
    .out_a(nm_out_a), .out_b(nm_out_b), .out_c(nm_out_c),
    .sound(nm_sound), .sample(nm_sample)
  );

  typedef struct {
    logic [5:0] mixer;
    logic [4:0] aa, ab, ac, env;
    logic       noise, ta, tb, tc;
    int         ea, eb, ec, ecnm;
  } vec_t;

  typedef struct {
    int a, b, c, cn;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb[$];
  int   lin_ref[32];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cen_div = 4;
  bit   m_primed = 1'b0;

  function automatic vec_t mkv(input logic [5:0] mx, input logic [4:0] aa, input logic [4:0] ab,
                               input logic [4:0] ac, input logic [4:0] ev, input logic nz,
                               input logic ta, input logic tb, input logic tc,
                               input int ea, input int eb, input int ec, input int ecnm);
    vec_t v;
    v.mixer = mx; v.aa = aa; v.ab = ab; v.ac = ac; v.env = ev;
    v.noise = nz; v.ta = ta; v.tb = tb; v.tc = tc;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ecnm = ecnm;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    mixer = v.mixer; amp_a = v.aa; amp_b = v.ab; amp_c = v.ac; env = v.env;
    noise = v.noise; tone_a = v.ta; tone_b = v.tb; tone_c = v.tc;
  endtask

  task automatic tick();
    cen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle clocks with cen low: sample must stay low there
  task automatic settle();
    if (cen_div > 1) begin
      cen = 1'b0;
      for (int k = 1; k < cen_div; k++) begin
        @(posedge clk);
        #1;
        chk("sample_cen_low", int'(sample), 0);
      end
    end
  endtask

  task automatic phase0(input vec_t v);
    exp_t p;
    exp_t e;
    tick();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      p = '{0, 0, 0, 0};
    end else begin
      p = sb.pop_front();
    end
    chk("out_a", int'(out_a), lin_ref[p.a]);
    chk("out_b", int'(out_b), lin_ref[p.b]);
    chk("out_c", int'(out_c), lin_ref[p.c]);
    chk("out_c_nomute", int'(nm_out_c), lin_ref[p.cn]);
    chk("sound", int'(sound), lin_ref[p.a] + lin_ref[p.b] + lin_ref[p.c]);
    chk("sample_snap", int'(sample), int'(m_primed));
    chk("lvl_a", int'(lvl_a), v.ea);
    chk("lvl_b", int'(lvl_b), v.eb);
    chk("lvl_c", int'(lvl_c), v.ec);
    chk("lvl_c_nomute", int'(nm_lvl_c), v.ecnm);
    e = '{v.ea, v.eb, v.ec, v.ecnm};
    sb.push_back(e);
    m_primed = 1'b1;
    settle();
  endtask

  task automatic other_tick();
    tick();
    chk("sample_mid", int'(sample), 0);
    settle();
  endtask

  task automatic run_pass(input vec_t v);
    apply(v);
    phase0(v);
    for (int k = 0; k < 3; k++) other_tick();
  endtask

  task automatic do_reset();
    exp_t z;
    cen = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_out_b", int'(out_b), 0);
    chk("rst_out_c", int'(out_c), 0);
    chk("rst_sound", int'(sound), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_lvl_a", int'(lvl_a), 0);
    chk("rst_lvl_b", int'(lvl_b), 0);
    chk("rst_lvl_c", int'(lvl_c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    z = '{0, 0, 0, 0};
    sb.delete();
    sb.push_back(z);
    m_primed = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    lin_ref[0] = 0;
    for (int n = 1; n < 32; n++) begin
      real x;
      x = 255.0 * (10.0 ** (-(31.0 - real'(n)) * 1.5 / 20.0));
      lin_ref[n] = $rtoi($floor(x + 0.5));
    end

    //            mixer  amp_a  amp_b  amp_c  env    nz    ta    tb    tc    la  lb  lc  lc_nm
    vecs[0]  = mkv(6'h3F, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 31, 31, 31, 31);
    vecs[1]  = mkv(6'h3E, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 31, 31, 31, 31);
    vecs[2]  = mkv(6'h3E, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0,  0, 31, 31, 31);
    vecs[3]  = mkv(6'h3E, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 31, 31, 31, 31);
    vecs[4]  = mkv(6'h3F, 5'h0F, 5'h10, 5'h0F, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0, 31, 23, 31, 31);
    vecs[5]  = mkv(6'h3F, 5'h0F, 5'h10, 5'h0F, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 31,  0, 31, 31);
    vecs[6]  = mkv(6'h37, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0,  0, 31, 31, 31);
    vecs[7]  = mkv(6'h37, 5'h0F, 5'h0F, 5'h0F, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 31, 31, 31, 31);
    vecs[8]  = mkv(6'h3F, 5'h0F, 5'h0F, 5'h00, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 31, 31,  0,  1);
    vecs[9]  = mkv(6'h3F, 5'h0F, 5'h0F, 5'h0E, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 31, 31, 29, 29);
    vecs[10] = mkv(6'h00, 5'h05, 5'h1F, 5'h1F, 5'd17, 1'b1, 1'b1, 1'b0, 1'b1, 11,  0, 17, 17);
    vecs[11] = mkv(6'h00, 5'h05, 5'h1F, 5'h1F, 5'd17, 1'b0, 1'b1, 1'b0, 1'b1,  0,  0,  0,  0);
    vecs[12] = mkv(6'h3F, 5'h10, 5'h08, 5'h01, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 31, 17,  3,  3);

    #2;
    do_reset();

    for (int mode = 0; mode < 2; mode++) begin
      cen_div = (mode == 0) ? 4 : 1;

      for (int i = 0; i <= NV; i++) run_pass(vecs[(i < NV) ? i : NV - 1]);

      // Amplitude change while the pass is at phase 2 must wait for the next snapshot
      apply(vecs[0]);
      phase0(vecs[0]);
      other_tick();
      amp_a = 5'h00;
      tick();
      chk("lvl_a_hold_ph2", int'(lvl_a), 31);
      settle();
      tick();
      chk("lvl_a_hold_ph3", int'(lvl_a), 31);
      settle();
      v = vecs[0];
      v.aa = 5'h00;
      v.ea = 0;
      run_pass(v);
      run_pass(vecs[0]);

      // Reset with the sequencer sitting at phase 2
      apply(vecs[0]);
      phase0(vecs[0]);
      other_tick();
      do_reset();
      run_pass(vecs[0]);
      run_pass(vecs[0]);
      run_pass(vecs[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
